spi_peripheral_fifo: RTL and testbench

Parametrised SPI peripheral (target-side) receiver that deserialises frames of configurable width in any of the four CPOL/CPHA modes. Completed frames are buffered in a show-ahead RX FIFO with a valid/ready pop handshake. The block adds CS-abort, bit-timeout and overflow detection. It sits between the board SPI pins and the image-load/command logic, and replaces the single-byte, mode-0-only peripheral. An optional CIPO transmit path is compiled in by macro.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rx_fifo.sv | 53 +++++
 rtl/spi_peripheral_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_spi_peripheral_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI peripheral receiver.
// FSM state encoding and SCLK sample-edge selection.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ABORT = 2'd2
    } spi_state_t;

    // 1: sample on rising SCLK, 0: sample on falling SCLK
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead RX FIFO; head is valid whenever empty is low.
// Extra pointer bit separates full from empty.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign count = wptr - rptr;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // A same-cycle pop frees the slot a push into a full FIFO needs
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr <= wptr + ONE;
            end
            if (rd_en) rptr <= rptr + ONE;
        end
    end

endmodule

// File: rtl/spi_peripheral_fifo.sv
// SPI target receiver, any CPOL/CPHA, with buffered RX frames.
// Define SPI_TX_EN to add the CIPO transmit path.
module spi_peripheral_fifo
    import spi_pkg::*;
#(
    parameter int FRAME_BITS     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          SCLK,
    input  logic                          COPI,
    input  logic                          spi_cs_n,
    input  logic                          rx_enable,
    output logic [FRAME_BITS-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic                          frame_error,
    output logic                          timeout
`ifdef SPI_TX_EN
    ,
    input  logic [FRAME_BITS-1:0]         tx_data,
    input  logic                          tx_load,
    output logic                          tx_ready,
    output logic                          CIPO,
    output logic                          cipo_oe
`endif
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic RISE = sample_on_rise(CPOL, CPHA);
    localparam logic IDLE_LVL = CPOL != 0;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] BIT_ONE = CW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE = TW'(1);

    logic [2:0]            sclk_q;
    logic [1:0]            copi_q;
    logic [1:0]            cs_q;
    logic                  cs_sync;
    logic                  copi_sync;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  sample_edge;
    spi_state_t            state;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] push_data;
    logic                  push_q;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  start;
    logic                  frame_done;

    // Idle-level SCLK and released CS at reset avoid a false edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= {3{IDLE_LVL}};
            copi_q <= '0;
            cs_q   <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            copi_q <= {copi_q[0], COPI};
            cs_q   <= {cs_q[0], spi_cs_n};
        end
    end

    assign cs_sync     = cs_q[1];
    assign copi_sync   = copi_q[1];
    assign sclk_rise   = sclk_q[1] && !sclk_q[2];
    assign sclk_fall   = !sclk_q[1] && sclk_q[2];
    assign sample_edge = RISE ? sclk_rise : sclk_fall;
    assign start       = (state == IDLE) && !cs_sync && rx_enable;
    assign frame_done  = (state == SHIFT) && !cs_sync && rx_enable &&
                         sample_edge && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            shift       <= '0;
            push_data   <= '0;
            push_q      <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    if (start) state <= SHIFT;
                end
                SHIFT: begin
                    if (cs_sync) begin
                        frame_error <= bit_cnt != '0;
                        bit_cnt     <= '0;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else if (!rx_enable) begin
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= ABORT;
                    end else if (sample_edge) begin
                        shift   <= {shift[FRAME_BITS-2:0], copi_sync};
                        tmo_cnt <= '0;
                        if (frame_done) begin
                            push_q    <= 1'b1;
                            push_data <= {shift[FRAME_BITS-2:0], copi_sync};
                            bit_cnt   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else if (bit_cnt != '0) begin
                        if (tmo_cnt == TMO_LAST) begin
                            timeout <= 1'b1;
                            bit_cnt <= '0;
                            tmo_cnt <= '0;
                            state   <= ABORT;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                ABORT: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    if (cs_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop      = rx_valid && rx_ready;
    assign rx_valid = !empty;

    spi_rx_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (rx_data),
        .full      (full),
        .empty     (empty),
        .count     (rx_count)
    );

    // A dropped frame wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (push_q && full && !pop) overflow <= 1'b1;
        else if (err_clr) overflow <= 1'b0;
    end

`ifdef SPI_TX_EN
    logic [FRAME_BITS-1:0] tx_hold;
    logic [FRAME_BITS-1:0] tx_sh;
    logic                  tx_full;
    logic                  tx_full_nxt;
    logic                  tx_skip;
    logic                  tx_copy;
    logic                  shift_edge;

    assign shift_edge = RISE ? sclk_fall : sclk_rise;
    assign tx_copy    = start || frame_done;
    assign CIPO       = tx_sh[FRAME_BITS-1];
    assign cipo_oe    = !cs_sync;

    always_comb begin
        tx_full_nxt = tx_full;
        if (tx_load && tx_ready) tx_full_nxt = 1'b1;
        else if (tx_copy) tx_full_nxt = 1'b0;
    end

    // The shift edge right after a copy must keep the new MSB on CIPO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_hold  <= '0;
            tx_sh    <= '0;
            tx_full  <= 1'b0;
            tx_ready <= 1'b0;
            tx_skip  <= 1'b0;
        end else begin
            tx_full  <= tx_full_nxt;
            tx_ready <= !tx_full_nxt;
            if (tx_load && tx_ready) tx_hold <= tx_data;
            if (tx_copy) begin
                tx_sh   <= tx_full ? tx_hold : '1;
                tx_skip <= (CPHA != 0) || frame_done;
            end else if ((state == SHIFT) && shift_edge) begin
                if (tx_skip) tx_skip <= 1'b0;
                else tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b1};
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_peripheral_fifo.sv
// Directed scoreboard bench for spi_peripheral_fifo in all four modes.
// Build with +define+SPI_TX_EN to also exercise the CIPO path.
`timescale 1ns/1ps
module tb_spi_peripheral_fifo;

    localparam int HP  = 6;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_enable;
    logic       err_clr;
    logic       sclk        [4];
    logic       copi        [4];
    logic       cs_n        [4];
    logic       rx_ready    [4];
    logic [7:0] rx_data     [4];
    logic       rx_valid    [4];
    logic [2:0] rx_count    [4];
    logic       overflow    [4];
    logic       frame_error [4];
    logic       timeout     [4];
`ifdef SPI_TX_EN
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready    [4];
    logic       cipo        [4];
    logic       cipo_oe     [4];
    logic [7:0] miso;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int fe_cnt   = 0;
    int to_cnt   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_peripheral_fifo #(
            .FRAME_BITS     (8),
            .FIFO_DEPTH     (4),
            .CPOL           (m / 2),
            .CPHA           (m % 2),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .SCLK        (sclk[m]),
            .COPI        (copi[m]),
            .spi_cs_n    (cs_n[m]),
            .rx_enable   (rx_enable),
            .rx_data     (rx_data[m]),
            .rx_valid    (rx_valid[m]),
            .rx_ready    (rx_ready[m]),
            .rx_count    (rx_count[m]),
            .overflow    (overflow[m]),
            .err_clr     (err_clr),
            .frame_error (frame_error[m]),
            .timeout     (timeout[m])
`ifdef SPI_TX_EN
            ,
            .tx_data     (tx_data),
            .tx_load     (tx_load),
            .tx_ready    (tx_ready[m]),
            .CIPO        (cipo[m]),
            .cipo_oe     (cipo_oe[m])
`endif
        );
    end

    // Count high cycles, so a stretched pulse also shows up
    always @(negedge clk) begin
        if (frame_error[0]) fe_cnt++;
        if (timeout[0]) to_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: CPHA=0 sets data before the leading edge,
    // CPHA=1 changes data on the leading edge.
    task automatic send_bits(input int m, input logic [7:0] v, input int n);
        logic pol;
        logic pha;
        pol = (m / 2) != 0;
        pha = (m % 2) != 0;
        for (int i = 0; i < n; i++) begin
            if (!pha) copi[m] = v[7-i];
            idle(HP);
`ifdef SPI_TX_EN
            if (!pha) miso = {miso[6:0], cipo[m]};
`endif
            sclk[m] = ~pol;
            if (pha) copi[m] = v[7-i];
            idle(HP);
`ifdef SPI_TX_EN
            if (pha) miso = {miso[6:0], cipo[m]};
`endif
            sclk[m] = pol;
        end
    endtask

    task automatic send_frame(input int m, input logic [7:0] v);
        send_bits(m, v, 8);
        exp_q.push_back(v);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        idle(HP);
    endtask

    task automatic cs_high(input int m);
        idle(HP);
        cs_n[m] = 1'b1;
        idle(2 * HP);
    endtask

    task automatic pop_check(input int m, input string tag);
        int t;
        logic [7:0] exp;
        t = 0;
        while (!rx_valid[m] && t < 100) begin
            idle(1);
            t++;
        end
        check({tag, "_valid"}, rx_valid[m], 1);
        exp = exp_q.pop_front();
        check(tag, rx_data[m], exp);
        rx_ready[m] = 1'b1;
        idle(1);
        rx_ready[m] = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_enable = 1'b1;
        err_clr   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            sclk[m]     = (m / 2) != 0;
            copi[m]     = 1'b0;
            cs_n[m]     = 1'b1;
            rx_ready[m] = 1'b0;
        end
`ifdef SPI_TX_EN
        tx_data = 8'h00;
        tx_load = 1'b0;
        miso    = 8'h00;
`endif
        idle(3);
        check("rst_valid", rx_valid[0], 0);
        check("rst_count", rx_count[0], 0);
        check("rst_data", rx_data[0], 0);
        check("rst_ovf", overflow[0], 0);
        check("rst_ferr", frame_error[0], 0);
        check("rst_tmo", timeout[0], 0);
`ifdef SPI_TX_EN
        check("rst_tx_ready", tx_ready[0], 0);
        check("rst_cipo", cipo[0], 0);
        check("rst_cipo_oe", cipo_oe[0], 0);
`endif
        rst_n = 1'b1;
        idle(4);

        // Two back-to-back frames in one CS window, mode 0
        cs_low(0);
        send_frame(0, 8'hA5);
        check("a_count1", rx_count[0], 1);
        send_frame(0, 8'h3C);
        check("a_count2", rx_count[0], 2);
        cs_high(0);
        pop_check(0, "a_pop0");
        check("a_count3", rx_count[0], 1);
        pop_check(0, "a_pop1");
        check("a_count4", rx_count[0], 0);
        check("a_no_ferr", fe_cnt, 0);

        // Remaining modes
        for (int m = 1; m < 4; m++) begin
            cs_low(m);
            send_frame(m, 8'h96);
            cs_high(m);
            pop_check(m, $sformatf("mode%0d_rx", m));
        end

        // Overflow: fifth frame dropped
        cs_low(0);
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i));
        send_bits(0, 8'h05, 8);
        cs_high(0);
        check("ovf_set", overflow[0], 1);
        check("ovf_count", rx_count[0], 4);
        for (int i = 0; i < 4; i++) pop_check(0, "ovf_pop");
        check("ovf_sticky", overflow[0], 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("ovf_clr", overflow[0], 0);

        // CS abort after 3 bits
        cs_low(0);
        send_bits(0, 8'hFF, 3);
        cs_high(0);
        check("ferr_pulse", fe_cnt, 1);
        check("ferr_count", rx_count[0], 0);
        cs_low(0);
        send_frame(0, 8'h55);
        cs_high(0);
        pop_check(0, "ferr_next");

        // Bit timeout, then edges ignored until CS toggles
        cs_low(0);
        send_bits(0, 8'hAA, 3);
        idle(TMO + 20);
        check("tmo_pulse", to_cnt, 1);
        send_bits(0, 8'hAA, 5);
        cs_high(0);
        check("tmo_nopush", rx_count[0], 0);
        check("tmo_noferr", fe_cnt, 1);
        check("tmo_single", to_cnt, 1);
        cs_low(0);
        send_frame(0, 8'h3C);
        cs_high(0);
        pop_check(0, "tmo_next");

        // rx_enable drop mid-frame: silent discard
        cs_low(0);
        send_bits(0, 8'hF0, 4);
        rx_enable = 1'b0;
        send_bits(0, 8'h0F, 4);
        cs_high(0);
        rx_enable = 1'b1;
        idle(2);
        check("en_nopush", rx_count[0], 0);
        check("en_noferr", fe_cnt, 1);
        check("en_notmo", to_cnt, 1);

`ifdef SPI_TX_EN
        check("tx_ready_idle", tx_ready[0], 1);
        tx_data = 8'hC3;
        tx_load = 1'b1;
        idle(1);
        tx_load = 1'b0;
        idle(1);
        check("tx_ready_full", tx_ready[0], 0);
        cs_low(0);
        check("tx_oe_on", cipo_oe[0], 1);
        send_frame(0, 8'h00);
        check("tx_c3", miso, 8'hC3);
        check("tx_ready_again", tx_ready[0], 1);
        send_frame(0, 8'h00);
        check("tx_underrun", miso, 8'hFF);
        cs_high(0);
        check("tx_oe_off", cipo_oe[0], 0);
        pop_check(0, "tx_rx0");
        pop_check(0, "tx_rx1");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
